// File: rtl/display_pkg.sv
// Shared types and default raster constants for the pixel FIFO display reader.
package display_pkg;

  localparam int PIXEL_W      = 24;

  localparam int H_ACTIVE     = 80;
  localparam int H_FRONT      = 4;
  localparam int H_SYNC       = 8;
  localparam int H_BACK       = 4;
  localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE     = 60;
  localparam int V_FRONT      = 1;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 2;
  localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic {
    WAIT_FILL = 1'b0,
    RUN       = 1'b1
  } state_t;

endpackage

// File: rtl/raster_timing_gen.sv
// Free-running horizontal/vertical raster counters with raw (unregistered) timing flags.
module raster_timing_gen
  import display_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic last_pixel
);

  localparam int H_TOT = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SW + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_end;
  logic          v_end;

  assign h_end = (hcnt == HW'(H_TOT - 1));
  assign v_end = (vcnt == VW'(V_TOT - 1));

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset in the sensitivity list, so every flop clears without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_end) begin
      hcnt <= '0;
      vcnt <= v_end ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Gated by en: the held-at-zero counters would otherwise look like pixel (0,0).
  assign active     = en && (hcnt < HW'(H_ACT)) && (vcnt < VW'(V_ACT));
  assign hsync_raw  = en && (hcnt >= HW'(H_ACT + H_FP)) && (hcnt < HW'(H_ACT + H_FP + H_SW));
  assign vsync_raw  = en && (vcnt >= VW'(V_ACT + V_FP)) && (vcnt < VW'(V_ACT + V_FP + V_SW));
  assign last_pixel = en && (hcnt == HW'(H_ACT - 1)) && (vcnt == VW'(V_ACT - 1));

endmodule

// File: rtl/fifo_display_reader.sv
// Drains RGB words from the pixel FIFO and emits a raster stream with DE and active-high syncs.
module fifo_display_reader
  import display_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PIXEL_W-1:0] fifo_dout,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  input  logic               src_done,
  output logic               REN,
  output logic [PIXEL_W-1:0] pixel,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_done,
  output logic               underflow
);

  state_t state;
  state_t state_next;
  logic   active;
  logic   hsync_raw;
  logic   vsync_raw;
  logic   last_pixel;
  logic   rd_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_FILL;
    else      state <= state_next;
  end

  // NOTE: a combinational block assigns a default to every output first so
  // no path through it can leave a value held, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_FILL: if (fifo_full || src_done) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = WAIT_FILL;
    endcase
  end

  raster_timing_gen u_timing (
    .clk        (clk),
    .rst        (rst),
    .en         (state == RUN),
    .active     (active),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .last_pixel (last_pixel)
  );

  assign REN = active & ~fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de         <= 1'b0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      frame_done <= 1'b0;
      rd_valid   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      de         <= active;
      hsync      <= hsync_raw;
      vsync      <= vsync_raw;
      frame_done <= last_pixel;
      rd_valid   <= REN;
      if (active && fifo_empty) underflow <= 1'b1;
    end
  end

  // FIFO read data arrives one cycle after REN, the same cycle the registered
  // de goes out; a starved active pixel shows black instead of stale data.
  assign pixel = rd_valid ? fifo_dout : '0;

endmodule

// File: tb/tb_fifo_display_reader.sv
// Directed bench for fifo_display_reader: raster timing, pixel order, underflow and reset behaviour.
module tb_fifo_display_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_full;
  logic        src_done;
  logic        REN;
  logic [23:0] pixel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_done;
  logic        underflow;

  int n_cmp = 0;
  int n_err = 0;
  int rd_ptr = 0;

  // scan results
  int sc_bad_ren, sc_bad_de, sc_bad_sync, sc_bad_pix, sc_bad_uf, sc_bad_fd;
  int sc_ren_n, sc_de_n, sc_hs_n, sc_vs_n, sc_fd_n, sc_fd_m;
  int sc_de_fall, sc_hs_rise, sc_hs_fall, sc_vs_rise;

  fifo_display_reader dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .src_done   (src_done),
    .REN        (REN),
    .pixel      (pixel),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // FIFO model: word value equals its index, returned one cycle after REN.
  always @(posedge clk) begin
    if (REN === 1'b1) begin
      fifo_dout <= 24'(rd_ptr);
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic do_reset();
    rst        = 1'b0;
    fifo_full  = 1'b0;
    src_done   = 1'b0;
    fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a negedge, one negedge after the start condition was sampled.
  // Counter position m is live between edges m and m+1; outputs show position m-1.
  // es >= 0 starves the FIFO for the three pixel positions es..es+2.
  task automatic scan(input int ncyc, input int es);
    int p, h, v, q, exp_idx;
    logic act, e_de, e_hs, e_vs, e_fd, e_uf, hole, prev_de, prev_hs, prev_vs;
    logic [23:0] e_pix;
    sc_bad_ren = 0; sc_bad_de = 0; sc_bad_sync = 0; sc_bad_pix = 0; sc_bad_uf = 0; sc_bad_fd = 0;
    sc_ren_n = 0; sc_de_n = 0; sc_hs_n = 0; sc_vs_n = 0; sc_fd_n = 0; sc_fd_m = -1;
    sc_de_fall = -1; sc_hs_rise = -1; sc_hs_fall = -1; sc_vs_rise = -1;
    prev_de = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0;
    exp_idx = rd_ptr;
    for (int m = 0; m < ncyc; m++) begin
      fifo_empty = (es >= 0) && (m >= es) && (m < es + 3);
      #1;
      p = m % 6240; h = p % 96; v = p / 96;
      act = (h < 80) && (v < 60);
      if (REN !== (act && !fifo_empty)) sc_bad_ren++;
      if (REN === 1'b1 && m < ncyc - 1) sc_ren_n++;
      q = m - 1;
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fd = 1'b0; e_uf = 1'b0; e_pix = '0;
      if (q >= 0) begin
        p = q % 6240; h = p % 96; v = p / 96;
        hole = (es >= 0) && (q >= es) && (q < es + 3);
        e_de = (h < 80) && (v < 60);
        e_hs = (h >= 84) && (h < 92);
        e_vs = (v >= 61) && (v < 63);
        e_fd = (h == 79) && (v == 59);
        e_uf = (es >= 0) && (q >= es);
        if (e_de && !hole) begin
          e_pix = 24'(exp_idx);
          exp_idx++;
        end
      end
      if (de !== e_de) sc_bad_de++;
      if (hsync !== e_hs || vsync !== e_vs) sc_bad_sync++;
      if (pixel !== e_pix) sc_bad_pix++;
      if (underflow !== e_uf) sc_bad_uf++;
      if (frame_done !== e_fd) sc_bad_fd++;
      if (de === 1'b1) sc_de_n++;
      if (hsync === 1'b1) sc_hs_n++;
      if (vsync === 1'b1) sc_vs_n++;
      if (frame_done === 1'b1) begin
        sc_fd_n++;
        if (sc_fd_m < 0) sc_fd_m = m;
      end
      if (prev_de && !de && sc_de_fall < 0) sc_de_fall = m;
      if (!prev_hs && hsync && sc_hs_rise < 0) sc_hs_rise = m;
      if (prev_hs && !hsync && sc_hs_fall < 0) sc_hs_fall = m;
      if (!prev_vs && vsync && sc_vs_rise < 0) sc_vs_rise = m;
      prev_de = de; prev_hs = hsync; prev_vs = vsync;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; fifo_full = 1'b0; src_done = 1'b0; fifo_empty = 1'b1;
    #1;
    n_cmp++;
    if ({REN, de, hsync, vsync, frame_done, underflow, pixel} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, want 0", {REN, de, hsync, vsync, frame_done, underflow, pixel});
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    fifo_empty = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if ({REN, de, hsync, vsync, frame_done, underflow, pixel} !== 30'd0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL idle_quiet: got %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_frame();
    do_reset();
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    scan(6241, -1);
    n_cmp++; if (sc_bad_ren !== 0)  begin n_err++; $display("FAIL frame_ren: got %0d bad cycles, want 0", sc_bad_ren); end
    n_cmp++; if (sc_bad_de !== 0)   begin n_err++; $display("FAIL frame_de: got %0d bad cycles, want 0", sc_bad_de); end
    n_cmp++; if (sc_bad_pix !== 0)  begin n_err++; $display("FAIL frame_pixel: got %0d bad cycles, want 0", sc_bad_pix); end
    n_cmp++; if (sc_bad_sync !== 0) begin n_err++; $display("FAIL frame_sync: got %0d bad cycles, want 0", sc_bad_sync); end
    n_cmp++; if (sc_bad_uf !== 0)   begin n_err++; $display("FAIL frame_underflow: got %0d bad cycles, want 0", sc_bad_uf); end
    n_cmp++; if (sc_de_n !== 4800)  begin n_err++; $display("FAIL frame_de_count: got %0d, want 4800", sc_de_n); end
    n_cmp++; if (sc_ren_n !== 4800) begin n_err++; $display("FAIL frame_ren_count: got %0d, want 4800", sc_ren_n); end
    n_cmp++; if (sc_fd_n !== 1)     begin n_err++; $display("FAIL frame_done_count: got %0d, want 1", sc_fd_n); end
    n_cmp++; if (sc_fd_m !== 5744)  begin n_err++; $display("FAIL frame_done_pos: got %0d, want 5744", sc_fd_m); end
    n_cmp++; if (sc_de_fall !== 81) begin n_err++; $display("FAIL first_de_fall: got %0d, want 81", sc_de_fall); end
    n_cmp++; if (sc_hs_rise - sc_de_fall !== 4) begin n_err++; $display("FAIL hsync_delay: got %0d, want 4", sc_hs_rise - sc_de_fall); end
    n_cmp++; if (sc_hs_fall - sc_hs_rise !== 8) begin n_err++; $display("FAIL hsync_width: got %0d, want 8", sc_hs_fall - sc_hs_rise); end
    n_cmp++; if (sc_hs_n !== 520)   begin n_err++; $display("FAIL hsync_total: got %0d, want 520", sc_hs_n); end
    n_cmp++; if (sc_vs_rise !== 5857) begin n_err++; $display("FAIL vsync_start: got %0d, want 5857", sc_vs_rise); end
    n_cmp++; if (sc_vs_n !== 192)   begin n_err++; $display("FAIL vsync_width: got %0d, want 192", sc_vs_n); end
  endtask

  task automatic test_underflow();
    do_reset();
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    scan(11 * 96 + 1, 10 * 96 + 20);
    n_cmp++; if (sc_bad_ren !== 0) begin n_err++; $display("FAIL uf_ren: got %0d bad cycles, want 0", sc_bad_ren); end
    n_cmp++; if (sc_bad_pix !== 0) begin n_err++; $display("FAIL uf_pixel: got %0d bad cycles, want 0", sc_bad_pix); end
    n_cmp++; if (sc_bad_de !== 0)  begin n_err++; $display("FAIL uf_de: got %0d bad cycles, want 0", sc_bad_de); end
    n_cmp++; if (sc_bad_uf !== 0)  begin n_err++; $display("FAIL uf_sticky: got %0d bad cycles, want 0", sc_bad_uf); end
    n_cmp++; if (sc_de_n !== 880)  begin n_err++; $display("FAIL uf_de_count: got %0d, want 880", sc_de_n); end
    n_cmp++; if (sc_ren_n !== 877) begin n_err++; $display("FAIL uf_reads: got %0d, want 877", sc_ren_n); end
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_held: got %b, want 1", underflow); end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    do_reset();
    src_done = 1'b1;
    @(negedge clk);
    scan(30 * 96 + 41, -1);
    n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL mid_pre_de: got %b, want 1", de); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({REN, de, hsync, vsync, frame_done, underflow, pixel} !== 30'd0) begin
      n_err++;
      $display("FAIL mid_async_clear: got %h, want 0", {REN, de, hsync, vsync, frame_done, underflow, pixel});
    end
    src_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if ({REN, de, hsync, vsync} !== 4'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mid_wait_fill: got %0d active cycles, want 0", bad); end
    src_done = 1'b1;
    @(negedge clk);
    scan(300, -1);
    n_cmp++;
    if (sc_bad_ren + sc_bad_de + sc_bad_pix + sc_bad_sync !== 0) begin
      n_err++;
      $display("FAIL mid_restart: got %0d bad cycles, want 0", sc_bad_ren + sc_bad_de + sc_bad_pix + sc_bad_sync);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    src_done = 1'b1;
    @(negedge clk);
    scan(2 * 6240 + 1, -1);
    n_cmp++; if (sc_bad_de + sc_bad_sync !== 0) begin n_err++; $display("FAIL b2b_timing: got %0d bad cycles, want 0", sc_bad_de + sc_bad_sync); end
    n_cmp++; if (sc_bad_pix !== 0)  begin n_err++; $display("FAIL b2b_pixel: got %0d bad cycles, want 0", sc_bad_pix); end
    n_cmp++; if (sc_bad_fd !== 0)   begin n_err++; $display("FAIL b2b_frame_done: got %0d bad cycles, want 0", sc_bad_fd); end
    n_cmp++; if (sc_fd_n !== 2)     begin n_err++; $display("FAIL b2b_frames: got %0d, want 2", sc_fd_n); end
    n_cmp++; if (sc_ren_n !== 9600) begin n_err++; $display("FAIL b2b_reads: got %0d, want 9600", sc_ren_n); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_underflow();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
